// File: rtl/array_seq_pkg.sv
// array_seq_pkg: opcode/state enums, op_fa encodings and row-index helpers for array_sequencer
package array_seq_pkg;
  typedef enum logic [2:0] {OP_NOP, OP_ADD, OP_AND, OP_XOR, OP_OR, OP_LI, OP_BRN, OP_RSV} op_e;
  typedef enum logic [2:0] {S_IDLE, S_SRC, S_EXEC, S_WB, S_BR, S_DONE} state_e;
  localparam logic [3:0] FA_SUM = 4'b0001;
  localparam logic [3:0] FA_AND = 4'b0010;
  localparam logic [3:0] FA_XOR = 4'b0100;
  localparam logic [3:0] FA_OR  = 4'b1000;
  // row position of the one-hot bit; indices past the array fall back to the zero row
  function automatic int onehot_idx(input int idx, input int rows);
    return (idx >= rows) ? 0 : idx;
  endfunction
  function automatic logic [3:0] fa_sel(input op_e op);
    return op == OP_ADD ? FA_SUM :
           op == OP_AND ? FA_AND :
           op == OP_XOR ? FA_XOR :
           op == OP_OR  ? FA_OR  : 4'b0000;
  endfunction
endpackage

// File: rtl/array_sequencer_row_decoder.sv
// array_sequencer_row_decoder: row index to one-hot row select, out-of-range index selects row 0
// ports: i_idx row index in, o_sel one-hot select out
module array_sequencer_row_decoder
  import array_seq_pkg::*;
#(
  parameter int ROWS = 32,
  parameter int AW = $clog2(ROWS)
) (
  input  logic [AW-1:0]   i_idx,
  output logic [ROWS-1:0] o_sel
);
  assign o_sel = ROWS'(1) << onehot_idx(int'(i_idx), ROWS);
endmodule

// File: rtl/array_sequencer.sv
// array_sequencer: expands one register-array instruction into row selects, write enables and op select
// ports: clk/rst (sync, active-low); instr_* valid/ready issue; rd_/wr_addr_*, wr_en, op_fa,
// carry_in, data_in_* array controls; overflow, last_row_msb array status;
// done_valid, ovf_flag, branch_taken completion back to issue
module array_sequencer
  import array_seq_pkg::*;
#(
  parameter int ROWS = 32,
  parameter int COLS = 32,
  parameter int AW = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [2:0]      instr_op,
  input  logic [AW-1:0]   instr_rs1,
  input  logic [AW-1:0]   instr_rs2,
  input  logic [AW-1:0]   instr_rd,
  input  logic [COLS-1:0] instr_imm,
  output logic [ROWS-1:0] rd_addr_up,
  output logic [ROWS-1:0] rd_addr_dn,
  output logic [ROWS-1:0] wr_addr_up,
  output logic [ROWS-1:0] wr_addr_dn,
  output logic [ROWS-1:0] wr_en,
  output logic [3:0]      op_fa,
  output logic            carry_in,
  output logic [COLS-1:0] data_in_up,
  output logic [COLS-1:0] data_in_dn,
  input  logic [ROWS-1:0] overflow,
  input  logic            last_row_msb,
  output logic            done_valid,
  output logic            ovf_flag,
  output logic            branch_taken
);
  state_e          r_state;
  op_e             r_op;
  logic [AW-1:0]   r_rd;
  logic            r_ready;
  logic [ROWS-1:0] r_rd_up;
  logic [ROWS-1:0] r_rd_dn;
  logic [ROWS-1:0] r_wr_up;
  logic [ROWS-1:0] r_wr_en;
  logic [3:0]      r_op_fa;
  logic [COLS-1:0] r_data_up;
  logic            r_done;
  logic            r_ovf;
  logic            r_br;
  op_e             w_op;
  logic [AW-1:0]   w_rd_idx;
  logic [ROWS-1:0] w_rs1_oh;
  logic [ROWS-1:0] w_rs2_oh;
  logic [ROWS-1:0] w_rd_oh;
  logic [ROWS-1:0] w_wr_oh;
  logic            w_ovf;
  assign w_op = op_e'(instr_op);
  // LI reaches WB straight from IDLE, so the destination is decoded from the live input there
  assign w_rd_idx = (r_state == S_IDLE) ? instr_rd : r_rd;
  array_sequencer_row_decoder #(.ROWS(ROWS), .AW(AW)) u_dec_rs1 (.i_idx(instr_rs1), .o_sel(w_rs1_oh));
  array_sequencer_row_decoder #(.ROWS(ROWS), .AW(AW)) u_dec_rs2 (.i_idx(instr_rs2), .o_sel(w_rs2_oh));
  array_sequencer_row_decoder #(.ROWS(ROWS), .AW(AW)) u_dec_rd (.i_idx(w_rd_idx), .o_sel(w_rd_oh));
  // row 0 is hardwired zero: its write enable and overflow never count
  assign w_wr_oh = w_rd_oh[0] ? '0 : w_rd_oh;
  assign w_ovf = |(overflow & w_wr_oh);
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_op <= OP_NOP;
      r_rd <= '0;
      r_ready <= 1'b1;
      r_rd_up <= '0;
      r_rd_dn <= '0;
      r_wr_up <= '0;
      r_wr_en <= '0;
      r_op_fa <= '0;
      r_data_up <= '0;
      r_done <= 1'b0;
      r_ovf <= 1'b0;
      r_br <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (instr_valid && r_ready) begin
          r_ready <= 1'b0;
          r_op <= w_op;
          r_rd <= instr_rd;
          case (w_op)
            OP_ADD, OP_AND, OP_XOR, OP_OR: begin
              r_state <= S_SRC;
              r_rd_up <= w_rs1_oh;
              r_rd_dn <= w_rs2_oh;
            end
            OP_LI: begin
              r_state <= S_WB;
              r_wr_up <= w_rd_oh;
              r_wr_en <= w_wr_oh;
              r_data_up <= instr_imm;
            end
            OP_BRN: r_state <= S_BR;
            default: begin
              r_state <= S_DONE;
              r_done <= 1'b1;
              r_ovf <= 1'b0;
            end
          endcase
        end
        S_SRC: begin
          r_state <= S_EXEC;
          r_op_fa <= fa_sel(r_op);
        end
        S_EXEC: begin
          r_state <= S_WB;
          r_wr_up <= w_rd_oh;
          r_wr_en <= w_wr_oh;
        end
        S_WB: begin
          r_state <= S_DONE;
          r_done <= 1'b1;
          r_ovf <= (r_op == OP_LI) ? 1'b0 : w_ovf;
          r_rd_up <= '0;
          r_rd_dn <= '0;
          r_wr_up <= '0;
          r_wr_en <= '0;
          r_op_fa <= '0;
          r_data_up <= '0;
        end
        S_BR: begin
          r_state <= S_DONE;
          r_done <= 1'b1;
          r_ovf <= 1'b0;
          r_br <= last_row_msb;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end
  assign instr_ready = r_ready;
  assign rd_addr_up = r_rd_up;
  assign rd_addr_dn = r_rd_dn;
  assign wr_addr_up = r_wr_up;
  assign wr_addr_dn = '0;
  assign wr_en = r_wr_en;
  assign op_fa = r_op_fa;
  assign carry_in = 1'b0;
  assign data_in_up = r_data_up;
  assign data_in_dn = '0;
  assign done_valid = r_done;
  assign ovf_flag = r_ovf;
  assign branch_taken = r_br;
endmodule

// File: tb/tb_array_sequencer.sv
// tb_array_sequencer: table, corner-case and random checks of array_sequencer against a cycle model
module tb_array_sequencer;
  localparam int ROWS = 32;
  localparam int COLS = 32;
  localparam int AW = 5;
  localparam logic [255:0] RST_SNAP = 256'd1 << 230;
  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] ovf_v;
    logic        msb;
    logic        exp_flag;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic instr_valid = 1'b0;
  logic instr_ready;
  logic [2:0] instr_op = '0;
  logic [AW-1:0] instr_rs1 = '0;
  logic [AW-1:0] instr_rs2 = '0;
  logic [AW-1:0] instr_rd = '0;
  logic [COLS-1:0] instr_imm = '0;
  logic [ROWS-1:0] rd_addr_up, rd_addr_dn, wr_addr_up, wr_addr_dn, wr_en;
  logic [3:0] op_fa;
  logic carry_in;
  logic [COLS-1:0] data_in_up, data_in_dn;
  logic [ROWS-1:0] overflow = '0;
  logic last_row_msb = 1'b0;
  logic done_valid, ovf_flag, branch_taken;
  int checks = 0;
  int failures = 0;
  bit ovf_known, br_known;
  logic exp_ovf, exp_br;
  vec_t tbl[11];
  always #5 clk = ~clk;
  array_sequencer #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .instr_imm(instr_imm), .rd_addr_up(rd_addr_up), .rd_addr_dn(rd_addr_dn),
    .wr_addr_up(wr_addr_up), .wr_addr_dn(wr_addr_dn), .wr_en(wr_en), .op_fa(op_fa),
    .carry_in(carry_in), .data_in_up(data_in_up), .data_in_dn(data_in_dn),
    .overflow(overflow), .last_row_msb(last_row_msb), .done_valid(done_valid),
    .ovf_flag(ovf_flag), .branch_taken(branch_taken)
  );
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [255:0] snap();
    return {25'd0, instr_ready, rd_addr_up, rd_addr_dn, wr_addr_up, wr_addr_dn, wr_en, op_fa,
            carry_in, data_in_up, data_in_dn, done_valid};
  endfunction
  function automatic int latency(input logic [2:0] op);
    return (op >= 3'd1 && op <= 3'd4) ? 4 : (op == 3'd5 || op == 3'd6) ? 2 : 1;
  endfunction
  // outputs expected k cycles after the accepting edge
  function automatic logic [255:0] exp_cycle(input logic [2:0] op, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm, input int k);
    logic [31:0] ru, rdn, wu, we, du;
    logic [3:0] fa;
    bit alu;
    int lat;
    lat = latency(op);
    alu = (op >= 3'd1 && op <= 3'd4);
    ru = '0; rdn = '0; wu = '0; we = '0; du = '0; fa = '0;
    if (alu && k <= 3) begin
      ru = 32'd1 << rs1;
      rdn = 32'd1 << rs2;
    end
    if (alu && k >= 2 && k <= 3) fa = 4'(1 << (op - 3'd1));
    if ((alu && k == 3) || (op == 3'd5 && k == 1)) begin
      wu = 32'd1 << rd;
      we = (rd == 5'd0) ? 32'd0 : wu;
    end
    if (op == 3'd5 && k == 1) du = imm;
    return {25'd0, (k > lat), ru, rdn, wu, 32'd0, we, fa, 1'b0, du, 32'd0, (k == lat)};
  endfunction
  task automatic run_instr(input string tag, input logic [2:0] op, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
      input logic [31:0] ovf_v, input logic msb);
    int lat;
    bit alu;
    lat = latency(op);
    alu = (op >= 3'd1 && op <= 3'd4);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = op; instr_rs1 = rs1; instr_rs2 = rs2; instr_rd = rd; instr_imm = imm;
    overflow = $urandom;
    last_row_msb = 1'($urandom);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == lat) begin
        ovf_known = alu || op == 3'd5;
        exp_ovf = (alu && rd != 5'd0) ? ovf_v[rd] : 1'b0;
        br_known = (op == 3'd6);
        exp_br = msb;
      end
      chk($sformatf("%s op=%0d ctl k=%0d", tag, op, k), snap(), exp_cycle(op, rs1, rs2, rd, imm, k));
      if (ovf_known) chk($sformatf("%s ovf_flag k=%0d", tag, k), 256'(ovf_flag), 256'(exp_ovf));
      if (br_known) chk($sformatf("%s branch_taken k=%0d", tag, k), 256'(branch_taken), 256'(exp_br));
      instr_valid = 1'b0;
      instr_op = 3'($urandom); instr_rs1 = 5'($urandom); instr_rs2 = 5'($urandom);
      instr_rd = 5'($urandom); instr_imm = $urandom;
      overflow = (alu && k == 3) ? ovf_v : $urandom;
      last_row_msb = (op == 3'd6 && k == 1) ? msb : 1'($urandom);
    end
  endtask
  initial begin
    tbl[0]  = '{3'd1, 5'd3,  5'd5,  5'd7,  32'h0,        32'h0000_0080, 1'b0, 1'b1};
    tbl[1]  = '{3'd5, 5'd0,  5'd0,  5'd4,  32'hDEADBEEF, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[2]  = '{3'd3, 5'd9,  5'd10, 5'd0,  32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[3]  = '{3'd6, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,         1'b1, 1'b1};
    tbl[4]  = '{3'd6, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,         1'b0, 1'b0};
    tbl[5]  = '{3'd0, 5'd1,  5'd2,  5'd3,  32'h0,        32'h0,         1'b0, 1'b0};
    tbl[6]  = '{3'd7, 5'd4,  5'd5,  5'd6,  32'h0,        32'h0,         1'b0, 1'b0};
    tbl[7]  = '{3'd2, 5'd31, 5'd30, 5'd31, 32'h0,        32'h8000_0000, 1'b0, 1'b1};
    tbl[8]  = '{3'd4, 5'd0,  5'd1,  5'd2,  32'h0,        32'hFFFF_FFFB, 1'b0, 1'b0};
    tbl[9]  = '{3'd5, 5'd0,  5'd0,  5'd0,  32'h12345678, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[10] = '{3'd1, 5'd1,  5'd1,  5'd1,  32'h0,        32'h0000_0002, 1'b0, 1'b1};
    repeat (2) @(negedge clk);
    chk("reset ctl", snap(), RST_SNAP);
    chk("reset ovf_flag", 256'(ovf_flag), 256'd0);
    chk("reset branch_taken", 256'(branch_taken), 256'd0);
    rst = 1'b1;
    ovf_known = 1'b1; exp_ovf = 1'b0;
    br_known = 1'b1; exp_br = 1'b0;
    for (int i = 0; i < 11; i++) begin
      run_instr($sformatf("tbl%0d", i), tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                tbl[i].imm, tbl[i].ovf_v, tbl[i].msb);
      if (tbl[i].op >= 3'd1 && tbl[i].op <= 3'd5)
        chk($sformatf("tbl%0d flag ovf", i), 256'(ovf_flag), 256'(tbl[i].exp_flag));
      if (tbl[i].op == 3'd6)
        chk($sformatf("tbl%0d flag branch", i), 256'(branch_taken), 256'(tbl[i].exp_flag));
    end
    @(negedge clk);
    overflow = '0;
    instr_valid = 1'b1;
    instr_op = 3'd1; instr_rs1 = 5'd1; instr_rs2 = 5'd2; instr_rd = 5'd3;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("b2b ready c=%0d", c), 256'(instr_ready), 256'd0);
      chk($sformatf("b2b done c=%0d", c), 256'(done_valid), 256'(c == 4));
      if (c == 4) begin
        instr_op = 3'd4; instr_rs1 = 5'd6; instr_rs2 = 5'd9; instr_rd = 5'd10;
      end
    end
    @(negedge clk);
    chk("b2b ready after done", 256'(instr_ready), 256'd1);
    chk("b2b first not re-run", 256'(rd_addr_up), 256'd0);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("b2b second accept", 256'(rd_addr_up), 256'(32'd1 << 6));
    chk("b2b second busy", 256'(instr_ready), 256'd0);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("b2b second done k=%0d", k), 256'(done_valid), 256'(k == 4));
      if (k == 3) chk("b2b second op_fa", 256'(op_fa), 256'(4'b1000));
    end
    ovf_known = 1'b1; exp_ovf = 1'b0; br_known = 1'b0;
    chk("b2b ovf", 256'(ovf_flag), 256'd0);
    @(negedge clk);
    overflow = '1;
    last_row_msb = 1'b1;
    instr_valid = 1'b1;
    instr_op = 3'd2; instr_rs1 = 5'd2; instr_rs2 = 5'd3; instr_rd = 5'd4;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("abort exec sel", 256'(rd_addr_up), 256'(32'd1 << 2));
    chk("abort exec op_fa", 256'(op_fa), 256'(4'b0010));
    rst = 1'b0;
    @(negedge clk);
    chk("abort reset ctl", snap(), RST_SNAP);
    chk("abort reset ovf", 256'(ovf_flag), 256'd0);
    chk("abort reset branch", 256'(branch_taken), 256'd0);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("abort no done c=%0d", c), 256'(done_valid), 256'd0);
      chk($sformatf("abort ready c=%0d", c), 256'(instr_ready), 256'd1);
    end
    ovf_known = 1'b1; exp_ovf = 1'b0; br_known = 1'b1; exp_br = 1'b0;
    for (int i = 0; i < 300; i++)
      run_instr("rnd", 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                $urandom, $urandom, 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/array_sequencer.md
Name: array_sequencer

Overview:
Micro-sequencer directly upstream of the cell array.
- Accepts one decoded register-array instruction per valid/ready handshake.
- Expands it into a fixed multi-cycle sequence of one-hot row selects, write enables, full-adder op select and carry-in for the array.
- Collects the per-row overflow and the last-row MSB, and returns a completion pulse with status flags to the issue stage.

Parameters:
ROWS, 32, number of array rows; row 0 is the hardwired zero row
COLS, 32, array row width in bits
AW, $clog2(ROWS), width of the row index fields

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset; synchronous, active-low (0 = reset)
instr_valid  in  1  instruction present
instr_ready  out  1  sequencer can accept an instruction
instr_op  in  3  0 NOP, 1 ADD, 2 AND, 3 XOR, 4 OR, 5 LI, 6 BRN; 7 is treated as NOP
instr_rs1  in  AW  source row driven on the up read bus
instr_rs2  in  AW  source row driven on the down read bus
instr_rd  in  AW  destination row
instr_imm  in  COLS  immediate for LI
rd_addr_up  out  ROWS  one-hot up-bus read select
rd_addr_dn  out  ROWS  one-hot down-bus read select
wr_addr_up  out  ROWS  one-hot up-bus write select
wr_addr_dn  out  ROWS  one-hot down-bus write select; always 0 in this revision
wr_en  out  ROWS  one-hot row write enable
op_fa  out  4  array op select: bit0 sum, bit1 and, bit2 xor, bit3 or
carry_in  out  1  array carry-in
data_in_up  out  COLS  up-bus write data
data_in_dn  out  COLS  down-bus write data; always 0
overflow  in  ROWS  per-row overflow from the array
last_row_msb  in  1  MSB of the last row
done_valid  out  1  one-cycle completion pulse
ovf_flag  out  1  overflow status of the completed instruction; valid with done_valid
branch_taken  out  1  BRN result; valid with done_valid

Behaviour:
- All outputs are registered. While rst=0 at a clock edge:
  - state goes to IDLE;
  - every output except instr_ready goes to 0;
  - instr_ready goes to 1;
  - any in-flight instruction is dropped and no done_valid is produced.
- FSM states: IDLE, SRC, EXEC, WB, BR, DONE.
- IDLE:
  - instr_ready=1; all selects, wr_en, op_fa and carry_in are 0.
  - On instr_valid & instr_ready (cycle T), latch op, rs1, rs2, rd and imm, and drop instr_ready.
  - Next state by op:
    - ALU op (ADD/AND/XOR/OR) -> SRC.
    - LI -> WB.
    - BRN -> BR.
    - NOP/7 -> DONE.
- SRC (cycle T+1): rd_addr_up=onehot(rs1), rd_addr_dn=onehot(rs2).
- EXEC (T+2):
  - read selects held.
  - op_fa: ADD=0001, AND=0010, XOR=0100, OR=1000.
  - carry_in=0.
- WB (T+3):
  - read selects and op_fa held.
  - wr_addr_up=onehot(rd).
  - wr_en=onehot(rd) only if rd!=0; writes to row 0 are suppressed entirely.
  - For LI: data_in_up=imm and op_fa=0000; read selects stay 0.
  - ovf_flag is captured at the end of WB: overflow[rd] for ALU ops, 0 for LI or rd=0.
- BR (T+1): branch_taken is captured from last_row_msb at the end of this cycle.
- DONE:
  - done_valid=1 for exactly one cycle.
  - All array controls return to 0 in the same cycle.
  - Next state is IDLE, where instr_ready=1.
- Latencies:
  - ALU op: done_valid at T+4.
  - LI: done_valid at T+2.
  - BRN: done_valid at T+2.
  - NOP: done_valid at T+1.
- Exactly one instruction is in flight; there is no overlap. instr_ready=0 from T+1 until state returns to IDLE.
- Row index >= ROWS (non-power-of-two ROWS): treated as row 0, i.e. reads zero and the write is suppressed.
- ovf_flag and branch_taken hold their last value until the next done_valid. Both clear to 0 on reset.
- Simultaneous valid while busy: ignored. The issuer must hold the instruction until ready.

Decomposition:
- Package array_seq_pkg:
  - op enum (NOP..BRN);
  - FSM state enum;
  - op_fa encoding constants FA_SUM, FA_AND, FA_XOR, FA_OR;
  - onehot function onehot(idx, ROWS) with out-of-range index mapped to row 0.
- Sub-module: none required.
- The optional helper row_decoder (AW -> ROWS one-hot, with range guard) is shared by the four select outputs.

Test Plan:
- Reset then ADD rs1=3, rs2=5, rd=7, with overflow[7]=1 during WB:
  - selects onehot(3) and onehot(5) from T+1;
  - op_fa=0001 at T+2;
  - wr_en=32'h80 at T+3;
  - done_valid at T+4 with ovf_flag=1.
- LI rd=4, imm=32'hDEADBEEF:
  - at T+1, data_in_up=DEADBEEF, wr_en=32'h10, wr_addr_up=32'h10;
  - done_valid at T+2; ovf_flag=0.
- XOR rd=0: full sequence runs, wr_en stays 0 throughout, done_valid at T+4 with ovf_flag=0.
- BRN with last_row_msb=1, then BRN with last_row_msb=0: branch_taken 1 then 0, each with done_valid at T+2.
- Back-to-back valid held high for ADD then OR: second accept occurs only in the cycle after the first done_valid (instr_ready 0 during T+1..T+4).
- rst=0 asserted during EXEC of an AND: the next cycle shows all outputs 0 and instr_ready=1, and no done_valid ever follows.
